// File: rtl/wash_pkg.sv
// Shared types for the wash actuator controller: sequencer op codes, motor FSM states
// and the default PWM width.
package wash_pkg;

    localparam int unsigned PWM_W_DEF = 8;

    typedef enum logic [2:0] {
        STARTED  = 3'd0,
        WASHING  = 3'd1,
        SPINNING = 3'd2,
        DRYING   = 3'd3,
        FINISHED = 3'd4,
        HALT     = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        M_IDLE,
        M_RUN,
        M_BRAKE,
        M_REVERSE
    } motor_st_e;

    // Unused codes 6 and 7 collapse onto HALT so downstream logic only sees legal ops.
    function automatic op_e decode_op(input logic [2:0] code);
        op_e op;
        if (code > 3'd5) begin
            op = HALT;
        end else begin
            op = op_e'(code);
        end
        return op;
    endfunction

    function automatic logic is_running(input op_e op);
        return (op == WASHING) || (op == SPINNING) || (op == DRYING);
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Free-running PWM counter with duty compare; output is high while counter < duty.
module pwm_gen
    import wash_pkg::*;
#(
    parameter int unsigned PWM_W = PWM_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty_i,
    output logic             pwm_o
);

    logic [PWM_W-1:0] cnt_q;
    logic [PWM_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        pwm_o = (cnt_q < duty_i);
    end

endmodule

// File: rtl/wash_actuator_ctrl.sv
// Actuator driver behind the wash sequencer: soft-ramped motor with reversal FSM,
// valves/heater, door interlock with post-stop hold, and end-of-cycle buzzer.
module wash_actuator_ctrl
    import wash_pkg::*;
#(
    parameter int unsigned          PWM_W     = PWM_W_DEF,
    parameter logic [PWM_W-1:0]     WASH_DUTY = 8'd128,
    parameter logic [PWM_W-1:0]     SPIN_DUTY = 8'd240,
    parameter logic [PWM_W-1:0]     DRY_DUTY  = 8'd64,
    parameter logic [PWM_W-1:0]     RAMP_STEP = 8'd4,
    parameter int unsigned          REV_TICKS = 16,
    parameter int unsigned          LOCK_HOLD = 8,
    parameter int unsigned          BUZZ_CYC  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] operation,
    input  logic       tick,
    output logic       motor_pwm,
    output logic       motor_dir,
    output logic       fill_valve,
    output logic       drain_pump,
    output logic       heater,
    output logic       door_lock,
    output logic       buzzer,
    output logic       motor_busy
);

    localparam int unsigned REV_W  = $clog2(REV_TICKS + 1);
    localparam int unsigned HOLD_W = $clog2(LOCK_HOLD + 1);
    localparam int unsigned BUZZ_W = $clog2(BUZZ_CYC + 1);

    op_e              op_q, op_d;
    motor_st_e        st_q, st_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [PWM_W-1:0] op_tgt, tgt;
    logic             dir_q, dir_d;
    logic [REV_W-1:0] rev_q, rev_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [BUZZ_W-1:0] buzz_q, buzz_d;
    logic             fill_q, drain_q, heat_q;

    assign op_d = decode_op(operation);

    always_comb begin
        case (op_q)
            WASHING:  op_tgt = WASH_DUTY;
            SPINNING: op_tgt = SPIN_DUTY;
            DRYING:   op_tgt = DRY_DUTY;
            default:  op_tgt = '0;
        endcase
    end

    // Reverse-running drum outside WASHING must stop first so dir can return to forward.
    always_comb begin
        tgt = op_tgt;
        if ((st_q == M_BRAKE) || (dir_q && (op_q != WASHING))) begin
            tgt = '0;
        end
    end

    always_comb begin
        duty_d = duty_q;
        if (tick) begin
            if (duty_q < tgt) begin
                if ((tgt - duty_q) < RAMP_STEP) begin
                    duty_d = tgt;
                end else begin
                    duty_d = duty_q + RAMP_STEP;
                end
            end else if (duty_q > tgt) begin
                if ((duty_q - tgt) < RAMP_STEP) begin
                    duty_d = tgt;
                end else begin
                    duty_d = duty_q - RAMP_STEP;
                end
            end
        end
    end

    always_comb begin
        st_d  = st_q;
        dir_d = dir_q;
        rev_d = rev_q;
        case (st_q)
            M_IDLE: begin
                rev_d = '0;
                if (tgt != '0) begin
                    st_d = M_RUN;
                end
            end
            M_RUN: begin
                // An op change takes priority over a reversal expiring on the same tick.
                if (op_q != WASHING) begin
                    rev_d = '0;
                    if (dir_q) begin
                        st_d = M_BRAKE;
                    end else if ((tgt == '0) && (duty_q == '0)) begin
                        st_d = M_IDLE;
                    end
                end else if (tick && (duty_q == tgt)) begin
                    if (rev_q == REV_W'(REV_TICKS - 1)) begin
                        rev_d = '0;
                        st_d  = M_BRAKE;
                    end else begin
                        rev_d = rev_q + 1'b1;
                    end
                end
            end
            M_BRAKE: begin
                if (duty_q == '0) begin
                    st_d = M_REVERSE;
                end
            end
            M_REVERSE: begin
                dir_d = (op_q == WASHING) ? ~dir_q : 1'b0;
                rev_d = '0;
                st_d  = (op_tgt != '0) ? M_RUN : M_IDLE;
            end
            default: begin
                st_d = M_IDLE;
            end
        endcase
    end

    always_comb begin
        hold_d = hold_q;
        if ((duty_q != '0) && (duty_d == '0) && !is_running(op_q)) begin
            hold_d = HOLD_W'(LOCK_HOLD);
        end else if (tick && (hold_q != '0)) begin
            hold_d = hold_q - 1'b1;
        end
    end

    always_comb begin
        buzz_d = buzz_q;
        if ((op_d == FINISHED) && (op_q != FINISHED)) begin
            buzz_d = BUZZ_W'(BUZZ_CYC);
        end else if (buzz_q != '0) begin
            buzz_d = buzz_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_q    <= HALT;
            st_q    <= M_IDLE;
            duty_q  <= '0;
            dir_q   <= 1'b0;
            rev_q   <= '0;
            hold_q  <= '0;
            buzz_q  <= '0;
            fill_q  <= 1'b0;
            drain_q <= 1'b0;
            heat_q  <= 1'b0;
        end else begin
            op_q    <= op_d;
            st_q    <= st_d;
            duty_q  <= duty_d;
            dir_q   <= dir_d;
            rev_q   <= rev_d;
            hold_q  <= hold_d;
            buzz_q  <= buzz_d;
            fill_q  <= (op_q == STARTED);
            drain_q <= (op_q == SPINNING);
            heat_q  <= (op_q == DRYING);
        end
    end

    pwm_gen #(
        .PWM_W (PWM_W)
    ) u_pwm_gen (
        .clk    (clk),
        .rst    (rst),
        .duty_i (duty_q),
        .pwm_o  (motor_pwm)
    );

    assign motor_dir  = dir_q;
    assign fill_valve = fill_q;
    assign drain_pump = drain_q;
    assign heater     = heat_q;
    assign motor_busy = (duty_q != '0);
    assign buzzer     = (buzz_q != '0);
    assign door_lock  = is_running(op_q) || (duty_q != '0) || (hold_q != '0);

endmodule

// File: tb/tb_wash_actuator_ctrl.sv
// Directed bench for wash_actuator_ctrl: op-decode vector table plus motor ramp,
// reversal, interlock and buzzer sequences.
module tb_wash_actuator_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] operation = 3'd5;
    logic       tick = 1'b0;
    logic       motor_pwm, motor_dir, fill_valve, drain_pump, heater, door_lock, buzzer;
    logic       motor_busy;

    wash_actuator_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .operation  (operation),
        .tick       (tick),
        .motor_pwm  (motor_pwm),
        .motor_dir  (motor_dir),
        .fill_valve (fill_valve),
        .drain_pump (drain_pump),
        .heater     (heater),
        .door_lock  (door_lock),
        .buzzer     (buzzer),
        .motor_busy (motor_busy)
    );

    always #5 clk = ~clk;

    wire [7:0] duty_w = dut.duty_q;

    typedef struct {
        logic [2:0] op;
        logic       fill;
        logic       drain;
        logic       heat;
        logic       lock;
        logic       buzz;
    } vec_t;

    vec_t vecs [9];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Direction must only flip while the drum was stopped on the previous clock.
    logic       prev_dir = 1'b0;
    logic [7:0] prev_duty = 8'd0;
    logic       prev_rst = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst && prev_rst && (motor_dir != prev_dir)) begin
                n_cmp++;
                if (prev_duty != 8'd0) begin
                    n_err++;
                    $display("FAIL dir_change_while_turning: duty was %0d, expected 0", prev_duty);
                end
            end
            prev_dir  = motor_dir;
            prev_duty = duty_w;
            prev_rst  = rst;
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int e;
        int n;
        int rose;
        int hi;
        int bz;
        int post;
        int lock_bad;
        int vbad;
        int last;

        //               op    fill  drain heat  lock  buzz
        vecs[0] = '{3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{3'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{3'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8] = '{3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset with SPINNING requested, then release.
        rst = 1'b0; operation = 3'd2; tick = 1'b1;
        @(negedge clk);
        cyc(2);
        chk("reset_outputs", {motor_pwm, motor_dir, fill_valve, drain_pump, heater, door_lock,
                              buzzer, motor_busy}, 0);
        chk("reset_duty", duty_w, 0);
        rst = 1'b1;
        cyc(1);
        chk("drain_after_1clk", drain_pump, 0);
        chk("fill_after_release", fill_valve, 0);
        cyc(1);
        chk("drain_after_2clk", drain_pump, 1);
        cyc(5);
        chk("spin_busy_before_reset", motor_busy, 1);
        rst = 1'b0;
        cyc(1);
        chk("midop_reset_outputs", {motor_pwm, motor_dir, fill_valve, drain_pump, heater,
                                    door_lock, buzzer, motor_busy}, 0);

        // Op decode table, motor frozen (no ticks).
        tick = 1'b0; operation = 3'd5;
        cyc(1);
        rst = 1'b1;
        for (int i = 0; i < 9; i++) begin
            operation = vecs[i].op;
            cyc(1);
            if (i > 0) begin
                chk("valves_latency", {fill_valve, drain_pump, heater},
                    {vecs[i-1].fill, vecs[i-1].drain, vecs[i-1].heat});
            end
            cyc(1);
            chk("tbl_fill", fill_valve, vecs[i].fill);
            chk("tbl_drain", drain_pump, vecs[i].drain);
            chk("tbl_heater", heater, vecs[i].heat);
            chk("tbl_lock", door_lock, vecs[i].lock);
            chk("tbl_buzzer", buzzer, vecs[i].buzz);
            chk("tbl_busy", motor_busy, 0);
            cyc(4);
        end

        // STARTED -> WASHING ramp, then reversal.
        rst = 1'b0; operation = 3'd0;
        cyc(2);
        rst = 1'b1; tick = 1'b1;
        cyc(3);
        chk("started_fill", fill_valve, 1);
        operation = 3'd1;
        k = 0;
        while (!motor_busy && k < 10) begin
            cyc(1);
            k++;
        end
        chk("wash_start", motor_busy, 1);
        e = 0;
        for (int s = 1; s <= 32; s++) begin
            e = (e + 4 > 128) ? 128 : e + 4;
            chk("wash_ramp_up", duty_w, e);
            if (s < 32) cyc(1);
        end
        chk("wash_fill_off", fill_valve, 0);
        n = 0;
        while (duty_w == 8'd128 && n < 40) begin
            n++;
            cyc(1);
        end
        chk("wash_at_speed_clks", n, 17);
        for (int s = 1; s <= 32; s++) begin
            chk("wash_brake", duty_w, 128 - 4 * s);
            chk("wash_brake_dir", motor_dir, 0);
            if (s < 32) cyc(1);
        end
        cyc(1);
        chk("reverse_wait_duty", duty_w, 0);
        chk("reverse_wait_dir", motor_dir, 0);
        cyc(1);
        chk("reverse_restart_duty", duty_w, 4);
        chk("reverse_dir", motor_dir, 1);
        k = 0;
        while (duty_w != 8'd128 && k < 40) begin
            cyc(1);
            k++;
        end
        chk("rev_reramp", duty_w, 128);
        chk("rev_reramp_dir", motor_dir, 1);

        // WASHING -> SPINNING while reversed.
        operation = 3'd2;
        cyc(2);
        chk("spin_drain", drain_pump, 1);
        chk("spin_fill", fill_valve, 0);
        rose = 0; last = duty_w; k = 0;
        while (motor_busy && k < 60) begin
            cyc(1);
            if (duty_w > last) rose = 1;
            last = duty_w;
            k++;
        end
        chk("spin_brake_stop", motor_busy, 0);
        chk("spin_brake_monotonic", rose, 0);
        k = 0;
        while (!motor_busy && k < 10) begin
            cyc(1);
            k++;
        end
        chk("spin_restart", motor_busy, 1);
        chk("spin_dir_fwd", motor_dir, 0);
        k = 0;
        while (duty_w != 8'd240 && k < 80) begin
            cyc(1);
            k++;
        end
        chk("spin_reach", duty_w, 240);
        cyc(3);
        chk("spin_hold", duty_w, 240);
        hi = 0;
        for (int c = 0; c < 256; c++) begin
            if (motor_pwm) hi++;
            cyc(1);
        end
        chk("pwm_high_of_256", hi, 240);

        // SPINNING -> DRYING -> FINISHED.
        operation = 3'd3;
        cyc(2);
        chk("dry_heater", heater, 1);
        chk("dry_drain_off", drain_pump, 0);
        k = 0;
        while (duty_w != 8'd64 && k < 80) begin
            cyc(1);
            k++;
        end
        chk("dry_reach", duty_w, 64);
        operation = 3'd4;
        bz = 0; post = 0; lock_bad = 0;
        for (int j = 1; j <= 60; j++) begin
            cyc(1);
            if (j == 2) chk("fin_heater_off", heater, 0);
            if (buzzer) bz++;
            if (motor_busy && !door_lock) lock_bad++;
            if (!motor_busy && door_lock) post++;
        end
        chk("fin_buzzer_clks", bz, 4);
        chk("fin_lock_while_busy", lock_bad, 0);
        chk("fin_lock_hold_ticks", post, 8);
        chk("fin_unlocked", door_lock, 0);

        // Code 7 behaves as HALT.
        rst = 1'b0; operation = 3'd1;
        cyc(1);
        rst = 1'b1;
        cyc(20);
        chk("halt7_pre_busy", motor_busy, 1);
        operation = 3'd7;
        vbad = 0;
        for (int j = 1; j <= 60; j++) begin
            cyc(1);
            if (j >= 2 && (fill_valve || drain_pump || heater || buzzer)) vbad++;
        end
        chk("halt7_no_valves", vbad, 0);
        chk("halt7_stopped", duty_w, 0);
        chk("halt7_dir", motor_dir, 0);
        chk("halt7_unlocked", door_lock, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
